// File: rtl/stopwatch.sv
// stopwatch: count-up elapsed-time counter (hours:mins:secs) advanced by a shared
// one-second tick, with start/stop/clear control, optional lap capture and a
// saturation state at MaxHours:59:59.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   - lap_i captures the current count into lap_*_o and sets lap_valid_o
//   undefined - lap_i ignored, lap_*_o and lap_valid_o tied to 0, no lap registers
//
// Parameters:
//   MaxHours      highest hours value before saturation (<= 31)
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   tick_i        one-cycle pulse per elapsed second (counted only while running)
//   start_stop_i  one-cycle pulse, toggles run/pause
//   clear_i       one-cycle pulse, zero count and laps, return to idle
//   lap_i         one-cycle pulse, capture current count
//   hours_o/mins_o/secs_o                    elapsed time
//   lap_hours_o/lap_mins_o/lap_secs_o        last captured time
//   lap_valid_o   a lap has been captured since the last clear/reset
//   running_o     counting
//   done_o        saturated at MaxHours:59:59
module stopwatch #(
  parameter int unsigned MaxHours = 23
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       start_stop_i,
  input  logic       clear_i,
  input  logic       lap_i,
  output logic [4:0] hours_o,
  output logic [5:0] mins_o,
  output logic [5:0] secs_o,
  output logic [4:0] lap_hours_o,
  output logic [5:0] lap_mins_o,
  output logic [5:0] lap_secs_o,
  output logic       lap_valid_o,
  output logic       running_o,
  output logic       done_o
);

  localparam logic [4:0] MaxH = 5'(MaxHours);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] mins_q, mins_d;
  logic [5:0] secs_q, secs_d;
  logic       running_q, running_d;
  logic       done_q, done_d;

  // Incremented count, computed unconditionally; used only on a counted tick.
  logic [4:0] inc_hours;
  logic [5:0] inc_mins;
  logic [5:0] inc_secs;
  logic       inc_at_max;

  always_comb begin
    inc_hours = hours_q;
    inc_mins  = mins_q;
    inc_secs  = secs_q + 6'd1;
    if (secs_q == 6'd59) begin
      inc_secs = 6'd0;
      if (mins_q == 6'd59) begin
        inc_mins  = 6'd0;
        inc_hours = hours_q + 5'd1;
      end else begin
        inc_mins = mins_q + 6'd1;
      end
    end
    inc_at_max = (inc_hours == MaxH) && (inc_mins == 6'd59) && (inc_secs == 6'd59);
  end

  always_comb begin
    state_d = state_q;
    hours_d = hours_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    if (clear_i) begin
      state_d = StIdle;
      hours_d = 5'd0;
      mins_d  = 6'd0;
      secs_d  = 6'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A tick coinciding with start is not counted.
          if (start_stop_i) state_d = StRun;
        end
        StRun: begin
          if (tick_i) begin
            hours_d = inc_hours;
            mins_d  = inc_mins;
            secs_d  = inc_secs;
          end
          // Saturation wins over a simultaneous pause request.
          if (tick_i && inc_at_max) begin
            state_d = StDone;
          end else if (start_stop_i) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (start_stop_i) state_d = StRun;
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
    running_d = (state_d == StRun);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      hours_q   <= 5'd0;
      mins_q    <= 6'd0;
      secs_q    <= 6'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hours_q   <= hours_d;
      mins_q    <= mins_d;
      secs_q    <= secs_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign hours_o   = hours_q;
  assign mins_o    = mins_q;
  assign secs_o    = secs_q;
  assign running_o = running_q;
  assign done_o    = done_q;

`ifdef STOPWATCH_LAP_EN
  logic [4:0] lap_hours_q, lap_hours_d;
  logic [5:0] lap_mins_q, lap_mins_d;
  logic [5:0] lap_secs_q, lap_secs_d;
  logic       lap_valid_q, lap_valid_d;

  // Captures the pre-increment count when a tick lands in the same cycle.
  always_comb begin
    lap_hours_d = lap_hours_q;
    lap_mins_d  = lap_mins_q;
    lap_secs_d  = lap_secs_q;
    lap_valid_d = lap_valid_q;
    if (clear_i) begin
      lap_hours_d = 5'd0;
      lap_mins_d  = 6'd0;
      lap_secs_d  = 6'd0;
      lap_valid_d = 1'b0;
    end else if (lap_i && (state_q == StRun || state_q == StPause)) begin
      lap_hours_d = hours_q;
      lap_mins_d  = mins_q;
      lap_secs_d  = secs_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lap_hours_q <= 5'd0;
      lap_mins_q  <= 6'd0;
      lap_secs_q  <= 6'd0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_hours_q <= lap_hours_d;
      lap_mins_q  <= lap_mins_d;
      lap_secs_q  <= lap_secs_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_hours_o = lap_hours_q;
  assign lap_mins_o  = lap_mins_q;
  assign lap_secs_o  = lap_secs_q;
  assign lap_valid_o = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap  = lap_i;
  assign lap_hours_o = 5'd0;
  assign lap_mins_o  = 6'd0;
  assign lap_secs_o  = 6'd0;
  assign lap_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench for stopwatch. The reference model keeps elapsed time as a
// single seconds total and derives hours/mins/secs by division.
module tb_stopwatch;

  localparam int unsigned MaxH  = 1;
  localparam int          Limit = MaxH * 3600 + 59 * 60 + 59;
`ifdef STOPWATCH_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [4:0] hours, lap_hours;
  logic [5:0] mins, secs, lap_mins, lap_secs;
  logic       lap_valid, running, done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_t   = 0;
  int m_lap = 0;
  bit m_lv  = 1'b0;
  int m_st  = MIdle;

  always #5 clk = ~clk;

  stopwatch #(.MaxHours(MaxH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tick_i      (tick),
    .start_stop_i(start_stop),
    .clear_i     (clear),
    .lap_i       (lap),
    .hours_o     (hours),
    .mins_o      (mins),
    .secs_o      (secs),
    .lap_hours_o (lap_hours),
    .lap_mins_o  (lap_mins),
    .lap_secs_o  (lap_secs),
    .lap_valid_o (lap_valid),
    .running_o   (running),
    .done_o      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void m_reset();
    m_t = 0; m_lap = 0; m_lv = 1'b0; m_st = MIdle;
  endfunction

  function automatic void m_update(input bit tk, input bit ss, input bit cl, input bit lp);
    if (cl) begin
      m_reset();
      return;
    end
    if (LapEn && lp && (m_st == MRun || m_st == MPause)) begin
      m_lap = m_t;
      m_lv  = 1'b1;
    end
    case (m_st)
      MIdle:  if (ss) m_st = MRun;
      MRun: begin
        if (tk) m_t++;
        if (m_t == Limit) m_st = MDone;
        else if (ss) m_st = MPause;
      end
      MPause: if (ss) m_st = MRun;
      default: ;
    endcase
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".hours"}, 32'(hours), m_t / 3600);
    check({tag, ".mins"}, 32'(mins), (m_t / 60) % 60);
    check({tag, ".secs"}, 32'(secs), m_t % 60);
    check({tag, ".running"}, 32'(running), 32'(m_st == MRun));
    check({tag, ".done"}, 32'(done), 32'(m_st == MDone));
    check({tag, ".lap_hours"}, 32'(lap_hours), m_lap / 3600);
    check({tag, ".lap_mins"}, 32'(lap_mins), (m_lap / 60) % 60);
    check({tag, ".lap_secs"}, 32'(lap_secs), m_lap % 60);
    check({tag, ".lap_valid"}, 32'(lap_valid), 32'(m_lv));
  endtask

  // Inputs are driven 1 time unit after a rising edge and sampled by the next one.
  task automatic step(input bit tk, input bit ss, input bit cl, input bit lp, input string tag);
    tick = tk; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    m_update(tk, ss, cl, lp);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    compare_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".h"}, 32'(hours), h);
    check({tag, ".m"}, 32'(mins), m);
    check({tag, ".s"}, 32'(secs), s);
  endtask

  initial begin
    // Reset state
    #12;
    compare_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Run 61 ticks, then pause and tick 5 more
    step(1'b0, 1'b1, 1'b0, 1'b0, "start");
    ticks(61, "run61");
    check_time("t61", 0, 1, 1);
    check("t61.running", 32'(running), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, "pause");
    ticks(5, "paused");
    check_time("paused_hold", 0, 1, 1);
    check("paused.running", 32'(running), 0);

    // Hour rollover
    step(1'b0, 1'b0, 1'b1, 1'b0, "clear1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "start2");
    ticks(3599, "to_59_59");
    check_time("pre_hour", 0, 59, 59);
    ticks(1, "hour_roll");
    check_time("hour_roll", 1, 0, 0);

    // Saturation at MaxH:59:59
    ticks(3599, "to_max");
    check_time("sat", 1, 59, 59);
    check("sat.done", 32'(done), 1);
    check("sat.running", 32'(running), 0);
    ticks(3, "sat_ticks");
    step(1'b1, 1'b1, 1'b0, 1'b0, "sat_ss");
    step(1'b0, 1'b1, 1'b0, 1'b1, "sat_lap");
    check_time("sat_hold", 1, 59, 59);
    step(1'b0, 1'b0, 1'b1, 1'b0, "sat_clear");
    check_time("sat_clear", 0, 0, 0);
    check("sat_clear.done", 32'(done), 0);

    // Lap coinciding with tick
    step(1'b0, 1'b1, 1'b0, 1'b0, "start3");
    ticks(10, "to10");
    step(1'b1, 1'b0, 1'b0, 1'b1, "lap_tick");
    check_time("lap_tick", 0, 0, 11);
    check("lap_tick.lap_secs", 32'(lap_secs), LapEn ? 10 : 0);
    check("lap_tick.lap_valid", 32'(lap_valid), 32'(LapEn));
    step(1'b0, 1'b0, 1'b1, 1'b0, "lap_clear");
    check("lap_clear.lap_valid", 32'(lap_valid), 0);
    check("lap_clear.lap_secs", 32'(lap_secs), 0);

    // tick + start_stop together in RUN, then in IDLE
    step(1'b0, 1'b1, 1'b0, 1'b0, "start4");
    ticks(5, "to5");
    step(1'b1, 1'b1, 1'b0, 1'b0, "run_tick_ss");
    check_time("run_tick_ss", 0, 0, 6);
    check("run_tick_ss.running", 32'(running), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "clear5");
    step(1'b1, 1'b1, 1'b0, 1'b0, "idle_tick_ss");
    check_time("idle_tick_ss", 0, 0, 0);
    check("idle_tick_ss.running", 32'(running), 1);

    // Asynchronous reset mid-run at 00:12:34
    step(1'b0, 1'b0, 1'b1, 1'b0, "clear6");
    step(1'b0, 1'b1, 1'b0, 1'b0, "start6");
    ticks(754, "to_12_34");
    check_time("pre_rst", 0, 12, 34);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ticks(4, "post_rst_idle");
    check_time("post_rst_idle", 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "post_rst_start");
    ticks(2, "post_rst_run");
    check_time("post_rst_run", 0, 0, 2);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 399) == 0), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
